disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each digit slot is enabled; legal range 2..2^20.
REQ-002 Parameter BLANK_LZ, default 1: 1 = leading-zero blanking on, 0 = all four digits always lit.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port load  input  1  one-cycle request to capture value.
REQ-006 Port value  input  14  unsigned binary value to display.
REQ-007 Port busy  output  1  conversion in progress; load ignored while high.
REQ-008 Port done  output  1  one-cycle pulse: new value committed to display.
REQ-009 Port ovf  output  1  last captured value exceeded 9999.
REQ-010 Port in_scan  output  2  index of active digit slot (0 = ones ... 3 = thousands).
REQ-011 Port digit_bcd  output  4  BCD digit of active slot, for the external 7-segment decoder.
REQ-012 Port seg_scan  output  4  active-low digit enables; bit i low = slot i lit.

Function
REQ-013 Capture: load=1 and busy=0 at edge t SHALL latch min(value, 9999) and set ovf = (value > 9999); busy=1 from edge t.
REQ-014 load=1 while busy=1 SHALL be dropped without effect; there is no queue.
REQ-015 Conversion SHALL be iterative shift-add-3 (double dabble): one bit per clock, 14 iterations on edges t+1..t+14.
REQ-016 At edge t+14 the 16-bit BCD result SHALL be written to the display register, busy SHALL clear, and done SHALL be 1 for exactly the following cycle.
REQ-017 The display register SHALL hold the previous value for the whole conversion; no partial result is ever displayed.
REQ-018 A load at the edge where busy clears (t+14) SHALL be ignored; the earliest accepted reload is edge t+15.
REQ-019 Prescaler SHALL count 0..SCAN_DIV-1 and wrap. At each wrap, in_scan SHALL advance 0->1->2->3->0.
REQ-020 Slot advance SHALL be independent of load, busy and conversion activity.
REQ-021 seg_scan SHALL be 1110, 1101, 1011 or 0111 for in_scan 0, 1, 2 or 3 respectively, except where REQ-022 applies.
REQ-022 With BLANK_LZ=1, slot i (i>=1) SHALL output seg_scan=1111 when display digits i..3 are all zero; slot 0 is never blanked.
REQ-023 digit_bcd SHALL equal display register nibble [4*in_scan+3 : 4*in_scan], registered together with in_scan and seg_scan so all three change on the same edge.

Reset
REQ-024 rst=1 at an edge SHALL force: display register 0, busy 0, done 0, ovf 0, prescaler 0, in_scan 0, digit_bcd 0, seg_scan 1110.
REQ-025 rst during a conversion SHALL abort it; the discarded result is never committed and done does not pulse.
REQ-026 rst has priority over a simultaneous load.

Structure
REQ-027 The shared display package SHALL hold: the digit count (4), BCD max (9999), the binary width (14), and the seg_scan one-hot-low constants.
REQ-028 The sequential converter SHALL be a sub-module bin2bcd_seq, with ports clk, rst, start, bin[13:0], busy, done and bcd[15:0]. Scan and blanking logic stay in the top module.

Verification
REQ-029 After reset, with SCAN_DIV=4: in_scan sequence is 0,1,2,3,0 with 4 cycles per slot; seg_scan is 1110, then 1111, 1111, 1111 (display 0, blanking on).
REQ-030 load with value=1234 at edge t -> busy is high on edges t..t+13; done=1 only in the cycle after edge t+14; the slots then show digit_bcd 4,3,2,1 with seg_scan 1110, 1101, 1011, 0111.
REQ-031 value=16383 -> display 9999, ovf=1; a subsequent load with value=0 -> display 0, ovf=0.
REQ-032 value=50 with BLANK_LZ=1 -> slots 0 and 1 lit (digits 0, 5); slots 2 and 3 give seg_scan 1111. Same value with BLANK_LZ=0 -> all four slots lit, digits 0,5,0,0.
REQ-033 load value=77 followed by load value=88 at edge t+5 -> the second load is dropped and 77 is displayed. load at t+14 is dropped; load at t+15 is accepted.
REQ-034 rst at edge t+7 of a conversion of 4321 -> no done pulse, display stays 0, all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed display scanner.
package disp_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_MAX    = 9999;
  localparam int unsigned BIN_W      = 14;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

  localparam logic [3:0] SEG_SLOT0 = 4'b1110;
  localparam logic [3:0] SEG_SLOT1 = 4'b1101;
  localparam logic [3:0] SEG_SLOT2 = 4'b1011;
  localparam logic [3:0] SEG_SLOT3 = 4'b0111;
  localparam logic [3:0] SEG_OFF   = 4'b1111;

  typedef enum logic {
    CONV_IDLE,
    CONV_RUN
  } conv_state_e;

  function automatic logic [3:0] seg_for_slot(input logic [1:0] slot);
    case (slot)
      2'd0:    return SEG_SLOT0;
      2'd1:    return SEG_SLOT1;
      2'd2:    return SEG_SLOT2;
      default: return SEG_SLOT3;
    endcase
  endfunction

  // A non-ones slot goes dark when it and every more significant digit are zero.
  function automatic logic slot_blank(input logic [BCD_W-1:0] bcd,
                                      input logic [1:0]       slot);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (i >= 32'(slot) && bcd[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    return (slot != 2'd0) && upper_zero;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter; result register only updates on completion.
module bin2bcd_seq
  import disp_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

  conv_state_e      state_q;
  logic [BIN_W-1:0] sh_q;
  logic [BCD_W-1:0] acc_q;
  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_d;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [BCD_W-1:0] bcd_q;

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_d = {acc_adj[BCD_W-2:0], sh_q[BIN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CONV_IDLE: begin
          if (start) begin
            sh_q    <= bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV_RUN;
          end
        end
        CONV_RUN: begin
          sh_q  <= sh_q << 1;
          acc_q <= acc_d;
          cnt_q <= cnt_q + 4'd1;
          // Last iteration commits straight into the visible register.
          if (cnt_q == LAST_ITER) begin
            bcd_q   <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= CONV_IDLE;
          end
        end
        default: state_q <= CONV_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Captures a binary value, converts it to BCD and time-multiplexes four digit slots.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [1:0]       in_scan,
  output logic [3:0]       digit_bcd,
  output logic [3:0]       seg_scan
);

  localparam int unsigned     PRE_W    = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BIN_W-1:0] BIN_MAX  = BIN_W'(BCD_MAX);

  logic             start;
  logic [BIN_W-1:0] clamped;
  logic             conv_busy;
  logic [BCD_W-1:0] disp_bcd;

  logic [PRE_W-1:0] pre_q;
  logic             pre_wrap;
  logic [1:0]       slot_q;
  logic [1:0]       slot_d;
  logic [3:0]       digit_q;
  logic [3:0]       digit_d;
  logic [3:0]       seg_q;
  logic [3:0]       seg_d;
  logic             ovf_q;

  assign start   = load && !conv_busy;
  assign clamped = (value > BIN_MAX) ? BIN_MAX : value;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (clamped),
    .busy  (conv_busy),
    .done  (done),
    .bcd   (disp_bcd)
  );

  // Digit and enable are derived from the next slot so all three outputs move together.
  always_comb begin
    pre_wrap = (pre_q == PRE_LAST);
    slot_d   = pre_wrap ? slot_q + 2'd1 : slot_q;
    digit_d  = disp_bcd[{slot_d, 2'b00} +: 4];
    seg_d    = seg_for_slot(slot_d);
    if (BLANK_LZ != 0 && slot_blank(disp_bcd, slot_d)) seg_d = SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      slot_q  <= '0;
      digit_q <= '0;
      seg_q   <= SEG_SLOT0;
      ovf_q   <= 1'b0;
    end else begin
      pre_q   <= pre_wrap ? '0 : pre_q + PRE_W'(1);
      slot_q  <= slot_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      if (start) ovf_q <= (value > BIN_MAX);
    end
  end

  assign busy      = conv_busy;
  assign ovf       = ovf_q;
  assign in_scan   = slot_q;
  assign digit_bcd = digit_q;
  assign seg_scan  = seg_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized self-checking bench for disp_scan_ctrl, with and without leading-zero blanking.
module tb_disp_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [13:0] value = '0;

  logic        busy, done, ovf;
  logic [1:0]  in_scan;
  logic [3:0]  digit_bcd, seg_scan;

  logic        nb_busy, nb_done, nb_ovf;
  logic [1:0]  nb_in_scan;
  logic [3:0]  nb_digit, nb_seg;

  int total = 0;
  int bad   = 0;
  int since_rst = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) since_rst <= 0;
    else     since_rst <= since_rst + 1;
  end

  disp_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy), .done(done), .ovf(ovf),
    .in_scan(in_scan), .digit_bcd(digit_bcd), .seg_scan(seg_scan)
  );

  disp_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(nb_busy), .done(nb_done), .ovf(nb_ovf),
    .in_scan(nb_in_scan), .digit_bcd(nb_digit), .seg_scan(nb_seg)
  );

  // ---------------- reference model ----------------
  function automatic int clampv(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] dec_digit(input int v, input int slot);
    return 4'((v / pow10(slot)) % 10);
  endfunction

  function automatic logic [3:0] exp_seg(input int v, input int slot, input bit blank);
    logic [3:0] one;
    if (blank && slot != 0 && v < pow10(slot)) return 4'b1111;
    one = 4'b0001;
    return ~(one << slot);
  endfunction

  function automatic int cur_slot();
    return (since_rst / DIV) % 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int s;
    rst = 1'b1; load = 1'b0; value = '0;
    tick(); tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    total++; if (in_scan !== 2'd0) begin bad++; $display("FAIL reset_in_scan: got %0d want 0", in_scan); end
    total++; if (digit_bcd !== 4'd0) begin bad++; $display("FAIL reset_digit: got %0d want 0", digit_bcd); end
    total++; if (seg_scan !== 4'b1110) begin bad++; $display("FAIL reset_seg: got %b want 1110", seg_scan); end
    for (int c = 0; c < 20; c++) begin
      tick();
      s = cur_slot();
      total++;
      if (in_scan !== 2'(s) || seg_scan !== exp_seg(0, s, 1'b1) || nb_seg !== exp_seg(0, s, 1'b0)) begin
        bad++;
        $display("FAIL reset_scan: in_scan=%0d seg=%b nb_seg=%b want %0d %b %b",
                 in_scan, seg_scan, nb_seg, s, exp_seg(0, s, 1'b1), exp_seg(0, s, 1'b0));
      end
    end
  endtask

  task automatic test_timing_1234();
    int s;
    load = 1'b1; value = 14'd1234;
    tick();                                   // edge t
    load = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1234_busy_t: got %b want 1", busy); end
    for (int k = 1; k <= 14; k++) begin
      tick();
      s = cur_slot();
      total++;
      if (k < 14 && (busy !== 1'b1 || done !== 1'b0)) begin
        bad++; $display("FAIL t1234_window k=%0d: busy=%b done=%b want 1 0", k, busy, done);
      end
      if (k == 14 && (busy !== 1'b0 || done !== 1'b1)) begin
        bad++; $display("FAIL t1234_commit: busy=%b done=%b want 0 1", busy, done);
      end
      total++;
      if (digit_bcd !== dec_digit(0, s) || seg_scan !== exp_seg(0, s, 1'b1)) begin
        bad++; $display("FAIL t1234_hold k=%0d: digit=%0d seg=%b want %0d %b",
                        k, digit_bcd, seg_scan, dec_digit(0, s), exp_seg(0, s, 1'b1));
      end
    end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL t1234_done_width: got %b want 0", done); end
    for (int c = 0; c < 16; c++) begin
      tick();
      s = cur_slot();
      total++;
      if (in_scan !== 2'(s) || digit_bcd !== dec_digit(1234, s) || seg_scan !== exp_seg(1234, s, 1'b1)) begin
        bad++; $display("FAIL t1234_scan: slot=%0d digit=%0d seg=%b want %0d %0d %b",
                        in_scan, digit_bcd, seg_scan, s, dec_digit(1234, s), exp_seg(1234, s, 1'b1));
      end
    end
  endtask

  task automatic test_drop();
    int s;
    load = 1'b1; value = 14'd77;
    tick();                                   // edge t
    for (int k = 1; k <= 13; k++) begin
      load  = (k == 5);
      value = (k == 5) ? 14'd88 : 14'd77;
      tick();
    end
    load = 1'b1; value = 14'd55;
    tick();                                   // edge t+14, must be dropped
    total++; if (busy !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL drop_t14: busy=%b done=%b want 0 1", busy, done);
    end
    value = 14'd66;
    tick();                                   // edge t+15, must be accepted
    load = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL drop_t15_accept: busy=%b done=%b want 1 0", busy, done);
    end
    for (int k = 16; k <= 28; k++) begin
      tick();
      s = cur_slot();
      total++;
      if (busy !== 1'b1 || digit_bcd !== dec_digit(77, s) || seg_scan !== exp_seg(77, s, 1'b1)) begin
        bad++; $display("FAIL drop_hold77 k=%0d: busy=%b digit=%0d seg=%b want 1 %0d %b",
                        k, busy, digit_bcd, seg_scan, dec_digit(77, s), exp_seg(77, s, 1'b1));
      end
    end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL drop_done66: got %b want 1", done); end
    tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      s = cur_slot();
      total++;
      if (digit_bcd !== dec_digit(66, s) || seg_scan !== exp_seg(66, s, 1'b1)) begin
        bad++; $display("FAIL drop_scan66: digit=%0d seg=%b want %0d %b",
                        digit_bcd, seg_scan, dec_digit(66, s), exp_seg(66, s, 1'b1));
      end
    end
  endtask

  task automatic test_ovf();
    int s, n;
    int vals[2] = '{16383, 0};
    for (int j = 0; j < 2; j++) begin
      load = 1'b1; value = 14'(vals[j]);
      tick();
      load = 1'b0;
      total++; if (ovf !== (vals[j] > 9999)) begin
        bad++; $display("FAIL ovf_flag v=%0d: got %b want %b", vals[j], ovf, (vals[j] > 9999));
      end
      n = 0;
      while (done !== 1'b1 && n < 40) begin tick(); n++; end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ovf_timeout v=%0d: done=%b want 1", vals[j], done); end
      tick();
      for (int c = 0; c < 16; c++) begin
        tick();
        s = cur_slot();
        total++;
        if (digit_bcd !== dec_digit(clampv(vals[j]), s) || seg_scan !== exp_seg(clampv(vals[j]), s, 1'b1)) begin
          bad++; $display("FAIL ovf_scan v=%0d: digit=%0d seg=%b want %0d %b", vals[j], digit_bcd, seg_scan,
                          dec_digit(clampv(vals[j]), s), exp_seg(clampv(vals[j]), s, 1'b1));
        end
      end
    end
  endtask

  task automatic test_blank_50();
    int s, n;
    load = 1'b1; value = 14'd50;
    tick();
    load = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL blank50_timeout: done=%b want 1", done); end
    tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      s = cur_slot();
      total++;
      if (digit_bcd !== dec_digit(50, s) || seg_scan !== exp_seg(50, s, 1'b1)) begin
        bad++; $display("FAIL blank50_lz1 slot=%0d: digit=%0d seg=%b want %0d %b",
                        s, digit_bcd, seg_scan, dec_digit(50, s), exp_seg(50, s, 1'b1));
      end
      total++;
      if (nb_in_scan !== 2'(s) || nb_digit !== dec_digit(50, s) || nb_seg !== exp_seg(50, s, 1'b0)) begin
        bad++; $display("FAIL blank50_lz0 slot=%0d: digit=%0d seg=%b want %0d %b",
                        s, nb_digit, nb_seg, dec_digit(50, s), exp_seg(50, s, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    int v, s, n;
    for (int it = 0; it < 12; it++) begin
      v = int'($urandom_range(0, 16383));
      if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 120));
      load = 1'b1; value = 14'(v);
      tick();
      total++; if (ovf !== (v > 9999) || nb_ovf !== (v > 9999)) begin
        bad++; $display("FAIL rand_ovf v=%0d: got %b %b want %b", v, ovf, nb_ovf, (v > 9999));
      end
      n = 0;
      do begin
        load  = 1'($urandom_range(0, 1));
        value = 14'($urandom);
        tick();
        n++;
      end while (done !== 1'b1 && n < 40);
      load = 1'b0;
      total++; if (done !== 1'b1 || nb_done !== 1'b1 || n != 14) begin
        bad++; $display("FAIL rand_latency v=%0d: done=%b nb_done=%b cycles=%0d want 1 1 14", v, done, nb_done, n);
      end
      tick();
      total++; if (busy !== 1'b0 || nb_busy !== 1'b0) begin
        bad++; $display("FAIL rand_t14_drop v=%0d: busy=%b nb_busy=%b want 0 0", v, busy, nb_busy);
      end
      for (int c = 0; c < 16; c++) begin
        tick();
        s = cur_slot();
        total++;
        if (in_scan !== 2'(s) || digit_bcd !== dec_digit(clampv(v), s) || seg_scan !== exp_seg(clampv(v), s, 1'b1)
            || nb_digit !== dec_digit(clampv(v), s) || nb_seg !== exp_seg(clampv(v), s, 1'b0)) begin
          bad++; $display("FAIL rand_scan v=%0d slot=%0d: digit=%0d seg=%b nb=%0d/%b want %0d %b/%b",
                          v, s, digit_bcd, seg_scan, nb_digit, nb_seg, dec_digit(clampv(v), s),
                          exp_seg(clampv(v), s, 1'b1), exp_seg(clampv(v), s, 1'b0));
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int s;
    load = 1'b1; value = 14'd4321;
    tick();                                   // edge t
    load = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    rst = 1'b1; load = 1'b1; value = 14'd9000;
    tick();                                   // edge t+7: reset wins over load
    rst = 1'b0; load = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      bad++; $display("FAIL abort_flags: busy=%b done=%b ovf=%b want 0 0 0", busy, done, ovf);
    end
    total++; if (in_scan !== 2'd0 || digit_bcd !== 4'd0 || seg_scan !== 4'b1110) begin
      bad++; $display("FAIL abort_scan_reset: slot=%0d digit=%0d seg=%b want 0 0 1110", in_scan, digit_bcd, seg_scan);
    end
    for (int c = 0; c < 24; c++) begin
      tick();
      s = cur_slot();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || digit_bcd !== 4'd0 || seg_scan !== exp_seg(0, s, 1'b1)) begin
        bad++; $display("FAIL abort_after: done=%b busy=%b digit=%0d seg=%b want 0 0 0 %b",
                        done, busy, digit_bcd, seg_scan, exp_seg(0, s, 1'b1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing_1234();
    test_drop();
    test_ovf();
    test_blank_50();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
